simproc_prog_loader: RTL and testbench
======================================

# simproc_prog_loader

Upstream program-load stage for the `tt_um_ieeeuoftasic_simproc` processor. It takes instruction bytes strobed in on the dedicated input pins and writes them into the processor's program RAM. While loading, it holds the processor core in reset, and releases it once the host ends the load. It sits between the top-level `ui_in`/`uio_in` pins and the core's program-memory write port.

## Interface
Parameters:
- `ADDR_W`, default 4: program RAM address width; capacity is 2^ADDR_W bytes.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design-selected; when 0, the FSM, counters and outputs hold.
- `load_req`  in  1  level from host, synchronous to `clk`; high requests load mode.
- `byte_in`  in  8  instruction byte from pins; must be stable while `byte_stb` is high and for 2 cycles after.
- `byte_stb`  in  1  asynchronous pin strobe; each rising edge delivers one byte.
- `mem_we`  out  1  program RAM write enable, one-cycle pulse.
- `mem_addr`  out  ADDR_W  program RAM write address.
- `mem_wdata`  out  8  program RAM write data.
- `cpu_rst_n`  out  1  active-low reset to the processor core.
- `busy`  out  1  high while in LOAD.
- `loaded_count`  out  ADDR_W+1  bytes written since entering LOAD.
- `overflow`  out  1  sticky flag; a strobe arrived with the RAM full.

## Operation
- **Synchronizer.** `byte_stb` passes through 2 flops (s1, s2), plus a history flop s3. `stb_edge = s2 & ~s3`. The synchronizer runs regardless of `ena`. Edges seen while `ena`=0 are dropped.
- **FSM states.** IDLE, LOAD, RUN.
  - IDLE -> LOAD when `load_req`=1.
  - LOAD -> RUN when `load_req`=0.
  - RUN -> LOAD when `load_req`=1.
  - There is no return to IDLE except by reset.
- **Entering LOAD (from IDLE or RUN):** `mem_addr` <= 0, `loaded_count` <= 0, `overflow` <= 0, `cpu_rst_n` <= 0, `busy` <= 1.
- **In LOAD, on `stb_edge`:**
  - If `loaded_count` < 2^ADDR_W: `mem_we` <= 1, `mem_wdata` <= `byte_in`, `mem_addr` <= current write pointer. The pointer and `loaded_count` then increment.
  - Otherwise: no write, and `overflow` <= 1.
- **Write pointer.** Internal register, ADDR_W wide. It does not wrap into valid writes, because the full check uses `loaded_count`, which is ADDR_W+1 bits.
- **`mem_we`.** Deasserted every cycle in which it is not set by a write.
- **Entering RUN:** `busy` <= 0, `cpu_rst_n` <= 1.
- **IDLE.** `cpu_rst_n`=0, so the core stays in reset until the first load completes. An empty load (0 bytes) still enters RUN.
- **Simultaneous events.**
  - `stb_edge` in the same cycle `load_req` falls: the byte is written, then the block moves to RUN.
  - `stb_edge` in IDLE or RUN: ignored, with no flag set.
- **Reset mid-load.** All state returns to reset values immediately (asynchronously). Bytes already written remain in RAM, but the count is lost.

## Timing
- **Reset values:** `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst_n`=0, `busy`=0, `loaded_count`=0, `overflow`=0, state=IDLE.
- **Byte latency.** Let edge N be the first edge at which `byte_stb`=1 is sampled into s1. Then `mem_we`, `mem_addr` and `mem_wdata` are valid after edge N+2, for exactly one cycle. `loaded_count` updates on the same edge.
- **Strobe timing.** Minimum `byte_stb` high and low times are 2 `clk` cycles each. The maximum sustained rate is 1 byte per 4 cycles.
- **Load entry.** `load_req` rising at edge M gives `busy`=1 and `cpu_rst_n`=0 after edge M.
- **Load exit.** `load_req` falling at edge M gives `busy`=0 and `cpu_rst_n`=1 after edge M.
- **`ena`=0.** Every registered output holds its value. Any `mem_we` pulse already in progress ends, i.e. it is forced to 0.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-cycle -> all outputs at reset values immediately; after release, `cpu_rst_n` stays 0 until the first load.
- **Basic load.** Raise `load_req`, strobe 0xA1, 0xB2, 0xC3, drop `load_req` -> 3 single-cycle `mem_we` pulses at addr 0,1,2 with the matching data, each 2 edges after the strobe is sampled; `loaded_count`=3; `cpu_rst_n`=1 after the drop.
- **Overflow** (ADDR_W=4). Strobe 17 bytes -> 16 writes at addr 0..15, `loaded_count`=16, `overflow`=1. A 17th `mem_we` never occurs.
- **Reload.** From RUN with `overflow`=1, raise `load_req` -> `cpu_rst_n`=0, `loaded_count`=0, `overflow`=0; the next byte is written to addr 0.
- **`ena` gating and stray strobes.** A strobe with `ena`=0 in LOAD produces no write and `loaded_count` is unchanged. A strobe in RUN produces no write and `overflow` stays 0.
- **Simultaneous edge and exit.** The strobe edge and the `load_req` fall land in the same cycle -> the byte is written at the next address, and `busy`=0 and `cpu_rst_n`=1 on that same edge.

Source files
------------

// File: rtl/simproc_prog_loader.sv
// Program-load stage: synchronizes the pin strobe, writes strobed bytes into the
// program RAM and holds the processor core in reset while a load is in progress.
module simproc_prog_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load_req,
    input  logic [7:0]        byte_in,
    input  logic              byte_stb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic [ADDR_W:0]   loaded_count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    // Full threshold; loaded_count is one bit wider than the pointer so it can reach it.
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    logic              s1_q, s2_q, s3_q;
    logic              stb_edge_s;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;

    // Strobe synchronizer and history flop; free-running regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= byte_stb;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign stb_edge_s = s2_q & ~s3_q;

    // Next-state and output logic; with ena low everything holds except mem_we.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rst_n_d = cpu_rst_n_q;
        busy_d      = busy_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        wptr_d      = wptr_q;
        if (ena) begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (load_req) begin
                        state_d     = ST_LOAD;
                        addr_d      = {ADDR_W{1'b0}};
                        count_d     = {(ADDR_W+1){1'b0}};
                        ovf_d       = 1'b0;
                        cpu_rst_n_d = 1'b0;
                        busy_d      = 1'b1;
                        wptr_d      = {ADDR_W{1'b0}};
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LOAD: begin
                    if (stb_edge_s) begin
                        if (count_q < CAP) begin
                            we_d    = 1'b1;
                            wdata_d = byte_in;
                            addr_d  = wptr_q;
                            wptr_d  = wptr_q + ADDR_W'(1);
                            count_d = count_q + (ADDR_W+1)'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        we_d = 1'b0;
                    end
                    // A byte landing on the same edge as the load_req fall is still written.
                    if (!load_req) begin
                        state_d     = ST_RUN;
                        busy_d      = 1'b0;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    cpu_rst_n_d = 1'b0;
                end
            endcase
        end else begin
            we_d = 1'b0;
        end
    end

    // State and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= 8'h00;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= {(ADDR_W+1){1'b0}};
            ovf_q       <= 1'b0;
            wptr_q      <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign busy         = busy_q;
    assign loaded_count = count_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_simproc_prog_loader.sv
// Randomized bench for simproc_prog_loader: a cycle-level behavioural model is
// compared with the DUT every cycle, plus literal checks at key points.
module tb_simproc_prog_loader;

    localparam int ADDR_W = 4;
    localparam int CAP    = 1 << ADDR_W;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic              load_req;
    logic [7:0]        byte_in;
    logic              byte_stb;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic [ADDR_W:0]   loaded_count;
    logic              overflow;

    int n_chk  = 0;
    int n_fail = 0;

    simproc_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .load_req     (load_req),
        .byte_in      (byte_in),
        .byte_stb     (byte_stb),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .loaded_count (loaded_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_mode;
    logic       m_we;
    int         m_addr;
    logic [7:0] m_wdata;
    logic       m_cpu;
    logic       m_busy;
    int         m_count;
    logic       m_ovf;
    int         cyc;
    logic       prev_stb;
    int         pend[$];

    task automatic model_reset();
        m_mode = M_IDLE; m_we = 1'b0; m_addr = 0; m_wdata = 8'h00;
        m_cpu = 1'b0; m_busy = 1'b0; m_count = 0; m_ovf = 1'b0;
        prev_stb = 1'b0;
        pend.delete();
    endtask

    task automatic model_enter_load();
        m_mode = M_LOAD; m_addr = 0; m_count = 0; m_ovf = 1'b0;
        m_cpu = 1'b0; m_busy = 1'b1;
    endtask

    // A strobe rise first sampled at edge N takes effect at edge N+2.
    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                logic ev;
                ev = 1'b0;
                if (pend.size() > 0 && pend[0] == cyc) begin
                    ev = 1'b1;
                    void'(pend.pop_front());
                end
                if (byte_stb && !prev_stb) pend.push_back(cyc + 2);
                prev_stb = byte_stb;
                cyc++;
                m_we = 1'b0;
                if (ena) begin
                    if (m_mode == M_LOAD) begin
                        if (ev) begin
                            if (m_count < CAP) begin
                                m_we = 1'b1; m_wdata = byte_in; m_addr = m_count;
                                m_count++;
                            end else begin
                                m_ovf = 1'b1;
                            end
                        end
                        if (!load_req) begin
                            m_mode = M_RUN; m_busy = 1'b0; m_cpu = 1'b1;
                        end
                    end else if (load_req) begin
                        model_enter_load();
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("mem_we",       32'(mem_we),       32'(m_we));
                chk("mem_addr",     32'(mem_addr),     32'(m_addr));
                chk("mem_wdata",    32'(mem_wdata),    32'(m_wdata));
                chk("cpu_rst_n",    32'(cpu_rst_n),    32'(m_cpu));
                chk("busy",         32'(busy),         32'(m_busy));
                chk("loaded_count", 32'(loaded_count), 32'(m_count));
                chk("overflow",     32'(overflow),     32'(m_ovf));
            end
        end
    end

    // Capture of what the DUT actually writes, for the literal checks.
    logic [7:0] cap_mem [CAP];
    int         wr_cnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mem_we) begin
                cap_mem[mem_addr] = mem_wdata;
                wr_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] b);
        byte_in  = b;
        byte_stb = 1'b1;
        tick(2 + $urandom_range(0, 1));
        byte_stb = 1'b0;
        tick(2 + $urandom_range(0, 1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},    32'(mem_we),       32'd0);
        chk({tag, "_addr"},  32'(mem_addr),     32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata),    32'd0);
        chk({tag, "_cpu"},   32'(cpu_rst_n),    32'd0);
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_count"}, 32'(loaded_count), 32'd0);
        chk({tag, "_ovf"},   32'(overflow),     32'd0);
    endtask

    logic [7:0] sent [CAP+1];
    int         wr0;

    initial begin
        rst_n = 1'b0; ena = 1'b1; load_req = 1'b0; byte_stb = 1'b0; byte_in = 8'h00;
        tick(2);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Stray strobe in IDLE: ignored, core stays in reset.
        strobe(8'h11);
        tick(2);
        chk("idle_cpu", 32'(cpu_rst_n), 32'd0);
        chk("idle_cnt", 32'(loaded_count), 32'd0);

        // Basic load.
        load_req = 1'b1;
        tick(1);
        chk("entry_busy", 32'(busy), 32'd1);
        wr0 = wr_cnt;
        strobe(8'hA1); strobe(8'hB2); strobe(8'hC3);
        tick(2);
        load_req = 1'b0;
        tick(1);
        chk("basic_count", 32'(loaded_count), 32'd3);
        chk("basic_cpu",   32'(cpu_rst_n), 32'd1);
        chk("basic_busy",  32'(busy), 32'd0);
        chk("basic_wr",    32'(wr_cnt - wr0), 32'd3);
        chk("basic_m0",    32'(cap_mem[0]), 32'hA1);
        chk("basic_m1",    32'(cap_mem[1]), 32'hB2);
        chk("basic_m2",    32'(cap_mem[2]), 32'hC3);

        // Stray strobe in RUN.
        wr0 = wr_cnt;
        strobe(8'h77);
        chk("run_stray_wr",  32'(wr_cnt - wr0), 32'd0);
        chk("run_stray_ovf", 32'(overflow), 32'd0);

        // Overflow: 17 bytes into a 16-byte RAM.
        load_req = 1'b1;
        tick(1);
        wr0 = wr_cnt;
        for (int i = 0; i < CAP + 1; i++) begin
            sent[i] = 8'($urandom);
            if (i == CAP) chk("ovf_before", 32'(overflow), 32'd0);
            strobe(sent[i]);
        end
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_count", 32'(loaded_count), 32'd16);
        chk("ovf_wr",    32'(wr_cnt - wr0), 32'd16);
        for (int i = 0; i < CAP; i++) chk("ovf_data", 32'(cap_mem[i]), 32'(sent[i]));
        load_req = 1'b0;
        tick(2);
        chk("ovf_run_flag", 32'(overflow), 32'd1);

        // Reload from RUN clears the flag and restarts at address 0.
        load_req = 1'b1;
        tick(1);
        chk("reload_cpu",   32'(cpu_rst_n), 32'd0);
        chk("reload_count", 32'(loaded_count), 32'd0);
        chk("reload_ovf",   32'(overflow), 32'd0);
        strobe(8'h3C);
        chk("reload_addr", 32'(mem_addr), 32'd0);
        chk("reload_data", 32'(cap_mem[0]), 32'h3C);

        // ena gating: strobe with ena low is dropped.
        ena = 1'b0;
        wr0 = wr_cnt;
        strobe(8'hEE);
        tick(2);
        ena = 1'b1;
        tick(2);
        chk("ena_count", 32'(loaded_count), 32'd1);
        chk("ena_wr",    32'(wr_cnt - wr0), 32'd0);

        // Strobe edge and load_req fall on the same clock edge.
        byte_in  = 8'h5A;
        byte_stb = 1'b1;
        tick(2);
        load_req = 1'b0;
        tick(1);
        chk("sim_we",   32'(mem_we), 32'd1);
        chk("sim_addr", 32'(mem_addr), 32'd1);
        chk("sim_data", 32'(mem_wdata), 32'h5A);
        chk("sim_busy", 32'(busy), 32'd0);
        chk("sim_cpu",  32'(cpu_rst_n), 32'd1);
        byte_stb = 1'b0;
        tick(3);

        // Randomized traffic checked by the model.
        for (int k = 0; k < 80; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                strobe(8'($urandom));
            end else if (r == 6) begin
                load_req = ~load_req;
                tick($urandom_range(1, 3));
            end else if (r == 7) begin
                ena = 1'b0;
                tick($urandom_range(1, 3));
                ena = 1'b1;
            end else if (r == 8) begin
                byte_in  = 8'($urandom);
                byte_stb = 1'b1;
                tick(2);
                ena = 1'b0;
                tick(1);
                byte_stb = 1'b0;
                ena = 1'b1;
                tick(2);
            end else begin
                tick($urandom_range(1, 4));
            end
        end

        // Asynchronous reset in the middle of a load.
        load_req = 1'b1;
        tick(1);
        strobe(8'h42);
        strobe(8'h43);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        load_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_cpu", 32'(cpu_rst_n), 32'd0);
        chk("post_rst_cnt", 32'(loaded_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
